// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
// Purpose: arbiter FSM state encoding and an index-width helper that never
//          returns zero, so one-entry vectors still get a legal 1-bit index.
// Ports:   none (package)
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin picker
// Purpose: find the first asserted request searching from start_ptr upward,
//          wrapping modulo N.
// Ports:   req_vec    in  [N-1:0]   request vector
//          start_ptr  in  [IW-1:0]  highest-priority index (must be < N)
//          any        out           at least one request asserted
//          winner_idx out [IW-1:0]  selected index (0 when none)
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_vec,
  input  logic [IW-1:0] start_ptr,
  output logic          any,
  output logic [IW-1:0] winner_idx
);

  // Walk offsets from farthest to nearest so the nearest asserted request
  // is the last one written and therefore wins.
  always_comb begin
    int idx;
    idx        = 0;
    any        = |req_vec;
    winner_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start_ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (i == idx && req_vec[i]) winner_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
// Purpose: grants the FIFO write port to one producer at a time for up to
//          BURST_LEN beats, honouring fifo_full, with round-robin fairness.
// Ports:   clk        in                   clock
//          rst_n      in                   async active-low reset
//          req_valid  in  [NUM_REQ-1:0]    producer i has a word
//          req_data   in  [NUM_REQ*DATA_W] packed producer data
//          req_ready  out [NUM_REQ-1:0]    beat accepted when valid && ready
//          fifo_full  in                   FIFO full flag
//          fifo_wen   out                  FIFO write enable
//          fifo_din   out [DATA_W-1:0]     FIFO write data
//          grant_vld  out                  a producer owns the port
//          grant_id   out [IW-1:0]         current owner index
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  localparam int IW       = idx_w(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wen,
  output logic [DATA_W-1:0]           fifo_din,
  output logic                        grant_vld,
  output logic [IW-1:0]               grant_id
);

  localparam int CW = idx_w(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;

  logic              pick_any;
  logic [IW-1:0]     pick_idx;
  logic              owner_valid;
  logic [DATA_W-1:0] owner_data;
  logic [NUM_REQ-1:0] owner_onehot;
  logic              xfer;

  fifo_rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_vec    (req_valid),
    .start_ptr  (rr_ptr_q),
    .any        (pick_any),
    .winner_idx (pick_idx)
  );

  // Owner-selected views of the request bus.
  always_comb begin
    owner_valid  = 1'b0;
    owner_data   = '0;
    owner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_valid     = req_valid[i];
        owner_data      = req_data[i*DATA_W +: DATA_W];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  // Full always wins, even if the FIFO is being read this same cycle.
  assign xfer = (state_q == ARB_BURST) && owner_valid && !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d    = ARB_BURST;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_BURST: begin
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
        // A full stall holds the grant; only a completed burst or the owner
        // withdrawing releases it. Exit always passes through IDLE.
        if ((xfer && beat_cnt_q == LAST_BEAT) || !owner_valid) begin
          state_d    = ARB_IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    fifo_wen  = 1'b0;
    fifo_din  = '0;
    grant_vld = 1'b0;
    grant_id  = owner_q;
    if (state_q == ARB_BURST) begin
      req_ready = owner_onehot & {NUM_REQ{!fifo_full}};
      fifo_wen  = xfer;
      fifo_din  = owner_data;
      grant_vld = 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wen;
  logic [DW-1:0]     fifo_din;
  logic              grant_vld;
  logic [1:0]        grant_id;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wen  (fifo_wen),
    .fifo_din  (fifo_din),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Producers: each holds a queue; valid shows the head word while enabled.
  int        pq[N][$];
  bit        en[N];
  logic [N-1:0] acc;

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = en[i] && (pq[i].size() > 0);
      req_data[i*DW +: DW]   = (pq[i].size() > 0) ? 8'(pq[i][0]) : 8'h00;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(pq[i].pop_front());
    apply();
  endtask

  // Log of what the DUT actually wrote, with cycle stamp.
  int cyc = 0;
  int log_id[$], log_dat[$], log_cyc[$];

  task automatic log_clear();
    log_id.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  function automatic int lg(input int which, input int k);
    if (k >= log_id.size()) return -1;
    case (which)
      0: return log_id[k];
      1: return log_dat[k];
      default: return log_cyc[k];
    endcase
  endfunction

  // Behavioural reference: who owns the port, where the search starts, and
  // how many beats the current grant has delivered.
  bit m_busy, n_busy;
  int m_owner, m_ptr, m_beats, n_owner, n_ptr, n_beats;

  always begin
    logic [N-1:0]  exp_ready;
    logic          exp_wen;
    logic [DW-1:0] exp_din;
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
      n_busy = 0; n_owner = 0; n_ptr = 0; n_beats = 0;
      chk("rst_wen",   fifo_wen,  0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gvld",  grant_vld, 0);
      chk("rst_gid",   grant_id,  0);
      chk("rst_din",   fifo_din,  0);
    end else begin
      exp_ready = (m_busy && !fifo_full) ? N'(1 << m_owner) : '0;
      exp_wen   = m_busy && req_valid[m_owner] && !fifo_full;
      exp_din   = m_busy ? req_data[m_owner*DW +: DW] : '0;
      chk("wen",   fifo_wen,  exp_wen);
      chk("ready", req_ready, exp_ready);
      chk("din",   fifo_din,  exp_din);
      chk("gvld",  grant_vld, m_busy);
      chk("gid",   grant_id,  m_owner);
      if (fifo_wen === 1'b1) begin
        log_id.push_back(int'(grant_id));
        log_dat.push_back(int'(fifo_din));
        log_cyc.push_back(cyc);
      end
      n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_beats = m_beats;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (req_valid[(m_ptr + k) % N]) begin
            n_busy = 1; n_owner = (m_ptr + k) % N; n_beats = 0;
            break;
          end
        end
      end else begin
        if (exp_wen) n_beats = m_beats + 1;
        if (n_beats == BL || !req_valid[m_owner]) begin
          n_busy = 0; n_beats = 0; n_ptr = (m_owner + 1) % N;
        end
      end
    end
    cyc++;
    @(posedge clk);
    if (rst_n) begin
      m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_beats = n_beats;
    end else begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin pq[i].delete(); en[i] = 0; end
    apply();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  int base, pushed, left;
  int t2_cyc[6] = '{1, 2, 3, 4, 6, 7};
  int t4_cyc[4] = '{1, 2, 6, 7};
  int t5_id[4]  = '{0, 0, 2, 2};
  int t5_dat[4] = '{8'h30, 8'h31, 8'h50, 8'h51};
  int t5_cyc[4] = '{1, 2, 5, 6};

  initial begin
    // 1: reset with random valids
    rst_n = 1'b0; fifo_full = 1'b0; req_valid = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin
      pq[i].push_back(i + 1);
      en[i] = bit'($urandom_range(0, 1));
    end
    en[0] = 1;
    apply();
    #1;
    chk("t1_wen", fifo_wen, 0);
    chk("t1_ready", req_ready, 0);
    chk("t1_gvld", grant_vld, 0);
    tick(); tick(); tick();
    for (int i = 0; i < N; i++) begin pq[i].delete(); en[i] = 0; end
    apply();
    rst_n = 1'b1;
    log_clear();
    repeat (5) tick();
    chk("t1_no_writes", log_id.size(), 0);
    chk("t1_gvld_idle", grant_vld, 0);

    // 2: single requester, burst split by the bubble
    do_reset();
    for (int k = 0; k < 6; k++) pq[2].push_back(8'h10 + k);
    en[2] = 1; apply(); log_clear(); base = cyc;
    tick();
    chk("t2_gvld", grant_vld, 1);
    chk("t2_gid", grant_id, 2);
    repeat (10) tick();
    chk("t2_n", log_id.size(), 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_id%0d", k),  lg(0, k), 2);
      chk($sformatf("t2_dat%0d", k), lg(1, k), 8'h10 + k);
      chk($sformatf("t2_cyc%0d", k), lg(2, k), base + t2_cyc[k]);
    end

    // 3: all four valid, round-robin order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < ((i == 0) ? 5 : 4); k++) pq[i].push_back(8'h40 + i*16 + k);
    for (int i = 0; i < N; i++) en[i] = 1;
    apply(); log_clear(); base = cyc;
    repeat (30) tick();
    chk("t3_n", log_id.size(), 17);
    for (int j = 0; j < 17; j++) begin
      chk($sformatf("t3_id%0d", j),  lg(0, j), (j < 16) ? j / 4 : 0);
      chk($sformatf("t3_dat%0d", j), lg(1, j), (j < 16) ? 8'h40 + (j/4)*16 + (j%4) : 8'h44);
      chk($sformatf("t3_cyc%0d", j), lg(2, j), base + ((j < 16) ? 1 + 5*(j/4) + (j%4) : 21));
    end

    // 4: full stall after two beats of requester 1
    do_reset();
    for (int k = 0; k < 4; k++) pq[1].push_back(8'h21 + k);
    en[1] = 1; apply(); log_clear(); base = cyc;
    tick(); tick(); tick();
    fifo_full = 1'b1;
    #1;
    chk("t4_wen", fifo_wen, 0);
    chk("t4_ready", req_ready, 0);
    chk("t4_gvld", grant_vld, 1);
    chk("t4_gid", grant_id, 1);
    tick(); tick(); tick();
    fifo_full = 1'b0;
    repeat (6) tick();
    chk("t4_n", log_id.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_dat%0d", k), lg(1, k), 8'h21 + k);
      chk($sformatf("t4_cyc%0d", k), lg(2, k), base + t4_cyc[k]);
    end

    // 5: owner drops valid early, next grant continues from pointer 1
    do_reset();
    pq[0].push_back(8'h30); pq[0].push_back(8'h31);
    pq[2].push_back(8'h50); pq[2].push_back(8'h51);
    en[0] = 1; en[2] = 1; apply(); log_clear(); base = cyc;
    repeat (10) tick();
    chk("t5_n", log_id.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5_id%0d", k),  lg(0, k), t5_id[k]);
      chk($sformatf("t5_dat%0d", k), lg(1, k), t5_dat[k]);
      chk($sformatf("t5_cyc%0d", k), lg(2, k), base + t5_cyc[k]);
    end

    // 6: reset mid-burst, pointer returns to 0
    do_reset();
    for (int k = 0; k < 4; k++) pq[3].push_back(8'h60 + k);
    en[3] = 1; apply(); log_clear();
    tick(); tick();
    chk("t6_pre_wen", fifo_wen, 1);
    chk("t6_pre_gid", grant_id, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_wen", fifo_wen, 0);
    chk("t6_gvld", grant_vld, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_din", fifo_din, 0);
    chk("t6_gid", grant_id, 0);
    chk("t6_log_n", log_id.size(), 1);
    for (int i = 0; i < N; i++) begin pq[i].delete(); en[i] = 0; end
    apply();
    tick(); tick();
    rst_n = 1'b1;
    pq[1].push_back(8'h71); pq[3].push_back(8'h73);
    en[1] = 1; en[3] = 1; apply(); log_clear();
    repeat (8) tick();
    chk("t6_first_id", lg(0, 0), 1);
    chk("t6_first_dat", lg(1, 0), 8'h71);
    chk("t6_second_id", lg(0, 1), 3);

    // Random traffic against the model, then drain and account for every word.
    do_reset();
    log_clear(); pushed = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0 && pq[i].size() < 6) begin
          pq[i].push_back(int'($urandom_range(0, 255)));
          pushed++;
        end
        if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
      end
      fifo_full = ($urandom_range(0, 4) == 0);
      apply();
      tick();
    end
    for (int i = 0; i < N; i++) en[i] = 1;
    fifo_full = 1'b0;
    apply();
    for (int w = 0; w < 400; w++) begin
      left = 0;
      for (int i = 0; i < N; i++) left += pq[i].size();
      if (left == 0) break;
      tick();
    end
    tick(); tick(); tick();
    chk("rnd_drained", left, 0);
    chk("rnd_writes", log_id.size(), pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
